jtag_simple: RTL and testbench
==============================

# jtag_simple

Minimal JTAG TAP controller that runs entirely in the system clock domain, with TCK, TMS and TDI oversampled as ordinary inputs. It provides three instructions:

- IDCODE: fixed 32-bit identification register.
- USER: 32-bit read/write user register, preset from `i_usercode`.
- BYPASS.

It sits between the board debug header and on-chip logic that exposes one 32-bit status/command word.

## Interface
- `IDCODE_VERSION`, default 1: IDCODE bits [31:28].
- `IDCODE_PART`, default 16'hBABE: IDCODE bits [27:12].
- `IDCODE_MANUFACTURER`, default 11'h001: IDCODE bits [11:1]. Bit 0 is always 1.
- `i_clock` in, 1 bit: system clock. This is the only clock.
- `i_reset` in, 1 bit: reset, asynchronous, active-low.
- `i_usercode` in, 32 bits: preset value for the USER register.
- `o_state` out, 4 bits: current TAP state, encoded as listed under Operation.
- `TCK` in, 1 bit: JTAG clock. Asynchronous to `i_clock` and sampled.
- `TMS` in, 1 bit: JTAG mode select.
- `TDI` in, 1 bit: JTAG data in.
- `TDO` out, 1 bit: JTAG data out. Always driven, never tristated.

## Operation
- **Input sampling:** TCK, TMS and TDI are registered once into the `i_clock` domain. A previous-TCK register detects edges. All TAP actions happen on the `i_clock` edge after a detected TCK rise, using the sampled TMS and TDI.
- **State encoding:** TLR=0, RTI=1, SelDR=2, CapDR=3, ShDR=4, Ex1DR=5, PauseDR=6, Ex2DR=7, UpdDR=8, SelIR=9, CapIR=10, ShIR=11, Ex1IR=12, PauseIR=13, Ex2IR=14, UpdIR=15.
- **Transitions:** the 16-state machine follows IEEE 1149.1 TMS transitions. Five TCK rises with TMS=1 reach TLR from any state.
- **Instruction register:** 4 bits. IDCODE=4'hB, USER=4'hE, BYPASS=4'hF. Any other code selects BYPASS. IR=IDCODE in TLR and after reset.
- **Capture (TCK rise while in CapIR or CapDR):** loads the shift register.
  - IR path: 4'b0001.
  - IDCODE: {VERSION[3:0], PART[15:0], MANUF[10:0], 1'b1}.
  - USER: the USER register.
  - BYPASS: 1'b0.
- **Shift:** happens on a TCK rise while in ShIR/ShDR **and TMS=0 only**. The shift register moves right and TDI enters the MSB of the active length (4 for IR, 32 for IDCODE/USER, 1 for BYPASS). The rise with TMS=1 that leaves Shift does not shift. Therefore N shift bits need exactly N TMS=0 ticks while in Shift.
- **Update (TCK rise while in UpdIR or UpdDR):**
  - UpdIR: IR takes the shift register [3:0].
  - UpdDR with USER selected: the USER register takes the shift register.
  - IDCODE and BYPASS ignore Update.
- **USER register:** loaded with `i_usercode` on reset and in TLR. Otherwise it changes only on UpdDR.
- **TDO:** equals the shift register bit 0 in ShIR/ShDR, else 0. The host samples it on the TCK fall.
- **Reset values:** state=TLR (`o_state`=0), IR=IDCODE, shift register=0, TDO=0, USER=`i_usercode`.
- **Reset mid-scan:** asynchronous reset aborts the scan. No Update occurs and the USER register is reloaded from `i_usercode`.

## Timing
- A TCK rise affects the state, shift register and TDO within 2 `i_clock` edges.
- TCK must be no faster than `i_clock`/3. Each TCK phase must be at least 1.5 `i_clock` periods.
- TMS and TDI must be stable for 2 `i_clock` periods around each TCK rise.
- `o_state` is registered and updates together with the internal state.
- Scan latency: the first TDO bit is valid after the CapDR→ShDR rise. Scan-out data equals the captured value, LSB first.

## Structure
- Shared package `jtag_pkg` holds:
  - the TAP state enum (encoding above);
  - instruction constants IDCODE, USER, BYPASS;
  - `IR_WIDTH`=4 and `DR_WIDTH`=32.
- One natural sub-module: `jtag_tap_fsm`, the 16-state TMS machine plus edge-detect input register. Data registers and the TDO mux stay in the top level.

## Test plan
- **Reset:** assert `i_reset`=0. Expect `o_state`=0 and TDO=0. Release, give five TMS=1 ticks, then one TMS=0 tick. Expect `o_state`=1 (RTI).
- **IDCODE:** shift IR 4'hB (the IR scan shifts out 4'b0001), then shift DR 32'h0. Expect TDO stream = 32'h1BABE003.
- **USER read:** with `i_usercode`=32'hB00BBABE, shift IR 4'hE, then DR 32'hCAFECAFE. Expect TDO stream 32'hB00BBABE.
- **USER write-back:** with USER still selected, shift DR 32'h0. Expect 32'hCAFECAFE.
- **BYPASS:** shift IR 4'hF (also try 4'h3), then DR bits 1,0,1,1. Expect TDO 0,1,0,1 (one-bit delay).
- **Reset mid-scan:** assert reset during a USER DR shift. Expect `o_state`=0, IR=IDCODE and USER=`i_usercode`. The next IDCODE scan is correct.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, instruction codes and register widths.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SH_DR    = 4'd4,
        EX1_DR   = 4'd5,
        PAUSE_DR = 4'd6,
        EX2_DR   = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SH_IR    = 4'd11,
        EX1_IR   = 4'd12,
        PAUSE_IR = 4'd13,
        EX2_IR   = 4'd14,
        UPD_IR   = 4'd15
    } tap_state_t;

    localparam int IR_WIDTH = 4;
    localparam int DR_WIDTH = 32;

    localparam logic [IR_WIDTH-1:0] IDCODE = 4'hB;
    localparam logic [IR_WIDTH-1:0] USER   = 4'hE;
    localparam logic [IR_WIDTH-1:0] BYPASS = 4'hF;

endpackage

// File: rtl/jtag_tap_fsm.sv
// Oversamples TCK/TMS/TDI into the system clock and steps the IEEE 1149.1
// TAP state machine once per detected TCK rise.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       tck,
    input  logic       tms,
    input  logic       tdi,
    output logic [3:0] state,
    output logic       tick,
    output logic       tms_s,
    output logic       tdi_s
);

    logic       tck_s;
    logic       tck_prev;
    tap_state_t cur;
    tap_state_t nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tck_s    <= 1'b0;
            tck_prev <= 1'b0;
            tms_s    <= 1'b1;
            tdi_s    <= 1'b0;
        end else begin
            tck_s    <= tck;
            tck_prev <= tck_s;
            tms_s    <= tms;
            tdi_s    <= tdi;
        end
    end

    // One-cycle strobe on the system clock following a sampled TCK rise.
    assign tick = tck_s & ~tck_prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur <= TLR;
        end else if (tick) begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            TLR:      nxt = tms_s ? TLR    : RTI;
            RTI:      nxt = tms_s ? SEL_DR : RTI;
            SEL_DR:   nxt = tms_s ? SEL_IR : CAP_DR;
            CAP_DR:   nxt = tms_s ? EX1_DR : SH_DR;
            SH_DR:    nxt = tms_s ? EX1_DR : SH_DR;
            EX1_DR:   nxt = tms_s ? UPD_DR : PAUSE_DR;
            PAUSE_DR: nxt = tms_s ? EX2_DR : PAUSE_DR;
            EX2_DR:   nxt = tms_s ? UPD_DR : SH_DR;
            UPD_DR:   nxt = tms_s ? SEL_DR : RTI;
            SEL_IR:   nxt = tms_s ? TLR    : CAP_IR;
            CAP_IR:   nxt = tms_s ? EX1_IR : SH_IR;
            SH_IR:    nxt = tms_s ? EX1_IR : SH_IR;
            EX1_IR:   nxt = tms_s ? UPD_IR : PAUSE_IR;
            PAUSE_IR: nxt = tms_s ? EX2_IR : PAUSE_IR;
            EX2_IR:   nxt = tms_s ? UPD_IR : SH_IR;
            UPD_IR:   nxt = tms_s ? SEL_DR : RTI;
            default:  nxt = TLR;
        endcase
    end

    assign state = cur;

endmodule

// File: rtl/jtag_simple.sv
// Minimal JTAG TAP in the system clock domain with IDCODE, USER and BYPASS
// data registers sharing one shift register.
module jtag_simple
    import jtag_pkg::*;
#(
    parameter logic [3:0]  IDCODE_VERSION      = 4'd1,
    parameter logic [15:0] IDCODE_PART         = 16'hBABE,
    parameter logic [10:0] IDCODE_MANUFACTURER = 11'h001
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_usercode,
    output logic [3:0]  o_state,
    input  logic        TCK,
    input  logic        TMS,
    input  logic        TDI,
    output logic        TDO
);

    localparam logic [DR_WIDTH-1:0] IDCODE_VALUE =
        {IDCODE_VERSION, IDCODE_PART, IDCODE_MANUFACTURER, 1'b1};

    logic [3:0]          state_raw;
    tap_state_t          state;
    logic                tick;
    logic                tms_s;
    logic                tdi_s;
    logic [IR_WIDTH-1:0] ir;
    logic [IR_WIDTH-1:0] instr;
    logic [DR_WIDTH-1:0] sr;
    logic [DR_WIDTH-1:0] user;

    jtag_tap_fsm u_fsm (
        .clock (i_clock),
        .reset (i_reset),
        .tck   (TCK),
        .tms   (TMS),
        .tdi   (TDI),
        .state (state_raw),
        .tick  (tick),
        .tms_s (tms_s),
        .tdi_s (tdi_s)
    );

    assign state   = tap_state_t'(state_raw);
    assign o_state = state_raw;

    // Unknown opcodes fall back to BYPASS so the chain length stays defined.
    assign instr = (ir == IDCODE || ir == USER) ? ir : BYPASS;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            ir   <= IDCODE;
            sr   <= '0;
            user <= i_usercode;
        end else begin
            if (state == TLR) begin
                ir   <= IDCODE;
                user <= i_usercode;
            end
            if (tick) begin
                case (state)
                    CAP_IR: sr <= 32'h0000_0001;
                    CAP_DR: begin
                        case (instr)
                            IDCODE:  sr <= IDCODE_VALUE;
                            USER:    sr <= user;
                            default: sr <= '0;
                        endcase
                    end
                    SH_IR: begin
                        if (!tms_s) sr <= {28'b0, tdi_s, sr[3:1]};
                    end
                    SH_DR: begin
                        if (!tms_s) begin
                            if (instr == BYPASS) sr <= {31'b0, tdi_s};
                            else                 sr <= {tdi_s, sr[31:1]};
                        end
                    end
                    UPD_IR: ir <= sr[IR_WIDTH-1:0];
                    UPD_DR: begin
                        if (instr == USER) user <= sr;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign TDO = (state == SH_IR || state == SH_DR) ? sr[0] : 1'b0;

endmodule

// File: tb/tb_jtag_simple.sv
// Directed bench for jtag_simple: TAP walk, IR/DR scan vectors and reset mid-scan.
module tb_jtag_simple;

    logic        i_clock;
    logic        i_reset;
    logic [31:0] i_usercode;
    logic [3:0]  o_state;
    logic        TCK;
    logic        TMS;
    logic        TDI;
    logic        TDO;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       tms;
        logic [3:0] exp_state;
    } walk_t;

    typedef struct {
        logic        is_ir;
        int          len;
        logic [31:0] din;
        logic [31:0] exp;
    } scan_t;

    jtag_simple dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_usercode (i_usercode),
        .o_state    (o_state),
        .TCK        (TCK),
        .TMS        (TMS),
        .TDI        (TDI),
        .TDO        (TDO)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One TCK period: TMS/TDI set after the previous fall, TDO sampled at the fall.
    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
        TMS = tms;
        TDI = tdi;
        repeat (3) @(negedge i_clock);
        TCK = 1'b1;
        repeat (3) @(negedge i_clock);
        tdo = TDO;
        TCK = 1'b0;
    endtask

    // From RTI: select, capture, shift len bits LSB first, update, back to RTI.
    task automatic scan(input logic is_ir, input int len, input logic [31:0] din,
                        output logic [31:0] dout);
        logic t;
        dout = '0;
        tck_cycle(1'b1, 1'b0, t);
        if (is_ir) tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        dout[0] = t;
        check("shift_state", {28'b0, o_state}, is_ir ? 32'd11 : 32'd4);
        for (int i = 0; i < len; i++) begin
            tck_cycle(1'b0, din[i], t);
            if (i < len - 1) dout[i+1] = t;
        end
        tck_cycle(1'b1, 1'b0, t);
        check("tdo_outside_shift", {31'b0, t}, 32'd0);
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        check("scan_end_state", {28'b0, o_state}, 32'd1);
    endtask

    walk_t       walk[24];
    scan_t       vec[11];
    logic [31:0] dout;
    logic        t;

    initial begin
        walk = '{'{1'b1, 4'd2},  '{1'b0, 4'd3},  '{1'b1, 4'd5},  '{1'b0, 4'd6},
                 '{1'b0, 4'd6},  '{1'b1, 4'd7},  '{1'b0, 4'd4},  '{1'b1, 4'd5},
                 '{1'b1, 4'd8},  '{1'b1, 4'd2},  '{1'b1, 4'd9},  '{1'b0, 4'd10},
                 '{1'b1, 4'd12}, '{1'b0, 4'd13}, '{1'b1, 4'd14}, '{1'b0, 4'd11},
                 '{1'b1, 4'd12}, '{1'b1, 4'd15}, '{1'b0, 4'd1},  '{1'b1, 4'd2},
                 '{1'b1, 4'd9},  '{1'b1, 4'd0},  '{1'b1, 4'd0},  '{1'b0, 4'd1}};
        vec  = '{'{1'b1, 4,  32'h0000000B, 32'h00000001},
                 '{1'b0, 32, 32'h00000000, 32'h1BABE003},
                 '{1'b1, 4,  32'h0000000E, 32'h00000001},
                 '{1'b0, 32, 32'hCAFECAFE, 32'hB00BBABE},
                 '{1'b0, 32, 32'h00000000, 32'hCAFECAFE},
                 '{1'b1, 4,  32'h0000000F, 32'h00000001},
                 '{1'b0, 4,  32'h0000000D, 32'h0000000A},
                 '{1'b1, 4,  32'h00000003, 32'h00000001},
                 '{1'b0, 4,  32'h0000000D, 32'h0000000A},
                 '{1'b1, 4,  32'h0000000B, 32'h00000001},
                 '{1'b0, 32, 32'h00000000, 32'h1BABE003}};

        i_reset    = 1'b0;
        i_usercode = 32'hB00BBABE;
        TCK        = 1'b0;
        TMS        = 1'b1;
        TDI        = 1'b0;

        repeat (4) @(negedge i_clock);
        check("reset_state", {28'b0, o_state}, 32'd0);
        check("reset_tdo", {31'b0, TDO}, 32'd0);
        i_reset = 1'b1;
        repeat (2) @(negedge i_clock);
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t);
        check("tlr_after_5", {28'b0, o_state}, 32'd0);
        tck_cycle(1'b0, 1'b0, t);
        check("rti_after_reset", {28'b0, o_state}, 32'd1);

        for (int i = 0; i < 24; i++) begin
            tck_cycle(walk[i].tms, 1'b0, t);
            check($sformatf("walk_%0d", i), {28'b0, o_state}, {28'b0, walk[i].exp_state});
        end

        for (int i = 0; i < 11; i++) begin
            scan(vec[i].is_ir, vec[i].len, vec[i].din, dout);
            check($sformatf("scan_%0d", i), dout, vec[i].exp);
        end

        // Abort a USER DR scan with reset after a few shifted ones.
        scan(1'b1, 4, 32'h0000000E, dout);
        check("mid_ir_out", dout, 32'h00000001);
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        check("mid_first_bit", {31'b0, t}, 32'd0);
        for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'b1, t);
        check("mid_in_shift", {28'b0, o_state}, 32'd4);
        #3 i_reset = 1'b0;
        #1;
        check("mid_reset_state", {28'b0, o_state}, 32'd0);
        check("mid_reset_tdo", {31'b0, TDO}, 32'd0);
        repeat (2) @(negedge i_clock);
        i_reset = 1'b1;
        repeat (2) @(negedge i_clock);
        tck_cycle(1'b0, 1'b0, t);
        check("mid_rti", {28'b0, o_state}, 32'd1);
        scan(1'b0, 32, 32'h00000000, dout);
        check("post_reset_idcode", dout, 32'h1BABE003);
        scan(1'b1, 4, 32'h0000000E, dout);
        check("post_reset_ir_out", dout, 32'h00000001);
        scan(1'b0, 32, 32'h00000000, dout);
        check("post_reset_user", dout, 32'hB00BBABE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
